// File: rtl/c7bifu_iq_mw_if.sv
// ---------------------------------------------------------------------------
// c7bifu_iq_mw_if
// Handshake bundle for the instruction queue: the fetch-beat write side
// (in_*) and the decode read side (out_*).
//   slave  : the queue's view (accepts beats, presents the head entry)
//   master : the environment's view (drives beats, consumes the head entry)
// ---------------------------------------------------------------------------
interface c7bifu_iq_mw_if #(
   parameter int FETCH_WORDS = 2,
   parameter int ADDR_W      = 32
);
   logic                     in_vld;
   logic                     in_rdy;
   logic [ADDR_W-1:0]        in_addr;
   logic [32*FETCH_WORDS-1:0] in_data;
   logic                     in_err;

   logic                     out_vld;
   logic                     out_rdy;
   logic [ADDR_W-1:0]        out_addr;
   logic [31:0]              out_inst;
   logic                     out_err;

   modport slave (
      input  in_vld, in_addr, in_data, in_err, out_rdy,
      output in_rdy, out_vld, out_addr, out_inst, out_err
   );

   modport master (
      output in_vld, in_addr, in_data, in_err, out_rdy,
      input  in_rdy, out_vld, out_addr, out_inst, out_err
   );
endinterface

// File: rtl/c7bifu_iq_mw.sv
// ---------------------------------------------------------------------------
// c7bifu_iq_mw
// Instruction queue between the BIU fetch return path and decode.
// A fetch beat of FETCH_WORDS instructions is written in one cycle; a
// non-zero word offset in the beat address drops the leading words (branch
// target mid-line). Entries leave one per cycle on a valid/ready handshake,
// each carrying its PC and the beat's fetch-error flag.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : synchronous clear of the queue (redirect), highest priority
//   bus         : in_* fetch beat handshake, out_* head entry handshake
//   level       : current occupancy in instructions
// ---------------------------------------------------------------------------
module c7bifu_iq_mw #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WORDS = 2,
   parameter int ADDR_W      = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   c7bifu_iq_mw_if.slave            bus,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int OFF_W = $clog2(FETCH_WORDS);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [31:0]       mem_inst [DEPTH];
   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic              mem_err  [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // k is the first valid word in the beat, n the number of words written.
   // One extra bit lets n hold the value FETCH_WORDS itself.
   logic [OFF_W:0]            k;
   logic [OFF_W:0]            n;
   logic [32*FETCH_WORDS-1:0] beat_shifted;
   logic [ADDR_W-1:0]         pc_first;
   logic [PTR_W-1:0]          free_slots;
   logic                      accept;
   logic                      pop;

   generate
      if (OFF_W == 0) begin : g_no_off
         assign k = '0;
      end else begin : g_off
         assign k = {1'b0, bus.in_addr[OFF_W+1:2]};
      end
   endgenerate

   // Shifting the beat down by k words puts word k+i at position i, so the
   // write loop below only needs constant slices. The PC of word k is simply
   // the beat address with the byte bits cleared.
   assign n            = (OFF_W+1)'(FETCH_WORDS) - k;
   assign beat_shifted = bus.in_data >> {k, 5'b00000};
   assign pc_first     = {bus.in_addr[ADDR_W-1:2], 2'b00};

   // Space check is deliberately conservative (assumes a full beat) and uses
   // only the registered level, so a same-cycle pop never opens the input.
   assign free_slots = PTR_W'(DEPTH) - level;
   assign bus.in_rdy = ~flush & (free_slots >= PTR_W'(FETCH_WORDS));
   assign bus.out_vld = ~flush & (level != '0);

   assign accept = bus.in_vld & bus.in_rdy;
   assign pop    = bus.out_vld & bus.out_rdy;

   // Head entry is presented straight from storage; stale contents show
   // through while out_vld is low.
   assign bus.out_addr = mem_addr[rd_ptr[IDX_W-1:0]];
   assign bus.out_inst = mem_inst[rd_ptr[IDX_W-1:0]];
   assign bus.out_err  = mem_err[rd_ptr[IDX_W-1:0]];

   // Pointer and occupancy bookkeeping; flush wins over accept and pop,
   // although both are already masked by flush through in_rdy/out_vld.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(n);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level <= level + (accept ? PTR_W'(n) : '0) - (pop ? PTR_W'(1) : '0);
      end
   end

   // Storage write: word k+i lands in slot wr_ptr+i; the index arithmetic
   // wraps naturally on IDX_W bits, so a beat may straddle the array end.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < DEPTH; s++) begin
            mem_inst[s] <= '0;
            mem_addr[s] <= '0;
            mem_err[s]  <= 1'b0;
         end
      end else if (accept) begin
         for (int i = 0; i < FETCH_WORDS; i++) begin
            if ((OFF_W+1)'(i) < n) begin
               mem_inst[wr_ptr[IDX_W-1:0] + IDX_W'(i)] <= beat_shifted[32*i +: 32];
               mem_addr[wr_ptr[IDX_W-1:0] + IDX_W'(i)] <= pc_first + ADDR_W'(4*i);
               mem_err[wr_ptr[IDX_W-1:0] + IDX_W'(i)]  <= bus.in_err;
            end
         end
      end
   end

endmodule

// File: tb/tb_c7bifu_iq_mw.sv
// ---------------------------------------------------------------------------
// tb_c7bifu_iq_mw
// Bench for the instruction queue (DEPTH=8, FETCH_WORDS=2, ADDR_W=32).
// Directed beats are driven from the stimulus process; a negedge monitor
// pushes the expected entries of every accepted beat into a scoreboard
// queue and pops/compares on every handshake at the output. The stimulus
// process additionally checks hand-computed values at key points.
// ---------------------------------------------------------------------------
module tb_c7bifu_iq_mw;

   localparam int DEPTH = 8;
   localparam int FW    = 2;
   localparam int AW    = 32;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   inst;
      logic          err;
   } entry_t;

   logic clk;
   logic resetn;
   logic flush;
   logic [$clog2(DEPTH):0] level;

   int tests;
   int fails;
   entry_t sb[$];

   c7bifu_iq_mw_if #(.FETCH_WORDS(FW), .ADDR_W(AW)) bus ();

   c7bifu_iq_mw #(.DEPTH(DEPTH), .FETCH_WORDS(FW), .ADDR_W(AW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .bus    (bus.slave),
      .level  (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generic comparison used by both processes.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: everything sampled at negedge, midway between active edges.
   always @(negedge clk) begin
      if (resetn) begin
         entry_t e;
         logic [63:0] sh;
         int k;
         checkOutput("mon_level", 64'(level), 64'(sb.size()));
         checkOutput("mon_in_rdy", 64'(bus.in_rdy), 64'(!flush && (DEPTH - sb.size() >= FW)));
         checkOutput("mon_out_vld", 64'(bus.out_vld), 64'(!flush && sb.size() != 0));
         if (bus.out_vld && bus.out_rdy && sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("mon_out_addr", 64'(bus.out_addr), 64'(e.addr));
            checkOutput("mon_out_inst", 64'(bus.out_inst), 64'(e.inst));
            checkOutput("mon_out_err", 64'(bus.out_err), 64'(e.err));
         end
         if (flush) begin
            sb.delete();
         end else if (bus.in_vld && bus.in_rdy) begin
            k  = int'(bus.in_addr[2]);
            sh = bus.in_data >> (32 * k);
            for (int i = 0; i < FW - k; i++) begin
               e.addr = {bus.in_addr[AW-1:3], 3'b000} + AW'(4 * (k + i));
               e.inst = sh[32*i +: 32];
               e.err  = bus.in_err;
               sb.push_back(e);
            end
         end
      end
   end

   // Present a beat (called at posedge+1) and hold it until accepted.
   task automatic applyStimulus(input logic [AW-1:0] addr, input logic [63:0] data, input logic err);
      int waited;
      bus.in_vld  = 1'b1;
      bus.in_addr = addr;
      bus.in_data = data;
      bus.in_err  = err;
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.in_rdy) break;
         waited++;
         if (waited > 50) begin
            checkOutput("accept_timeout", 64'(0), 64'(1));
            break;
         end
      end
      @(posedge clk); #1;
      bus.in_vld = 1'b0;
   endtask

   // Run one cycle with out_rdy high (called at posedge+1).
   task automatic popOne();
      bus.out_rdy = 1'b1;
      @(posedge clk); #1;
      bus.out_rdy = 1'b0;
   endtask

   task automatic drainAll();
      int guard;
      guard = 0;
      bus.out_rdy = 1'b1;
      while (sb.size() != 0 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.out_rdy = 1'b0;
      checkOutput("drain_empty", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      tests = 0;
      fails = 0;
      resetn = 1'b0;
      flush = 1'b0;
      bus.in_vld = 1'b0;
      bus.in_addr = '0;
      bus.in_data = '0;
      bus.in_err = 1'b0;
      bus.out_rdy = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_vld", 64'(bus.out_vld), 64'(0));
      checkOutput("rst_out_addr", 64'(bus.out_addr), 64'(0));
      checkOutput("rst_out_inst", 64'(bus.out_inst), 64'(0));
      checkOutput("rst_out_err", 64'(bus.out_err), 64'(0));
      checkOutput("rst_level", 64'(level), 64'(0));
      checkOutput("rst_in_rdy", 64'(bus.in_rdy), 64'(1));
      @(posedge clk); #1;
      resetn = 1'b1;

      // Aligned beat, then pop with zero-latency presentation
      applyStimulus(32'h1000, {32'hBBBB0002, 32'hAAAA0001}, 1'b0);
      @(negedge clk);
      checkOutput("b1_level", 64'(level), 64'(2));
      checkOutput("b1_out_vld", 64'(bus.out_vld), 64'(1));
      checkOutput("b1_addr0", 64'(bus.out_addr), 64'(32'h1000));
      checkOutput("b1_inst0", 64'(bus.out_inst), 64'(32'hAAAA0001));
      @(posedge clk); #1;
      popOne();
      @(negedge clk);
      checkOutput("b1_addr1", 64'(bus.out_addr), 64'(32'h1004));
      checkOutput("b1_inst1", 64'(bus.out_inst), 64'(32'hBBBB0002));
      @(posedge clk); #1;
      drainAll();

      // Unaligned beat: only the upper word is written
      applyStimulus(32'h2004, {32'h22, 32'h11}, 1'b0);
      @(negedge clk);
      checkOutput("ua_level", 64'(level), 64'(1));
      checkOutput("ua_addr", 64'(bus.out_addr), 64'(32'h2004));
      checkOutput("ua_inst", 64'(bus.out_inst), 64'(32'h22));
      @(posedge clk); #1;
      drainAll();

      // Fill to capacity (wraps slot 7 -> 0), then back-pressured 5th beat
      applyStimulus(32'h4000, {32'h40000002, 32'h40000001}, 1'b0);
      applyStimulus(32'h4008, {32'h40000004, 32'h40000003}, 1'b0);
      applyStimulus(32'h4010, {32'h40000006, 32'h40000005}, 1'b0);
      applyStimulus(32'h4018, {32'h40000008, 32'h40000007}, 1'b0);
      @(negedge clk);
      checkOutput("full_level", 64'(level), 64'(8));
      checkOutput("full_in_rdy", 64'(bus.in_rdy), 64'(0));
      @(posedge clk); #1;
      bus.in_vld  = 1'b1;
      bus.in_addr = 32'h4020;
      bus.in_data = {32'h4000000A, 32'h40000009};
      bus.in_err  = 1'b0;
      bus.out_rdy = 1'b1;
      @(negedge clk);
      checkOutput("l8_hold_in_rdy", 64'(bus.in_rdy), 64'(0));
      @(negedge clk);
      checkOutput("l7_level", 64'(level), 64'(7));
      checkOutput("l7_in_rdy", 64'(bus.in_rdy), 64'(0));
      @(posedge clk); #1;
      bus.out_rdy = 1'b0;
      @(negedge clk);
      checkOutput("l6_in_rdy", 64'(bus.in_rdy), 64'(1));
      @(posedge clk); #1;
      bus.in_vld = 1'b0;
      @(negedge clk);
      checkOutput("refill_level", 64'(level), 64'(8));
      @(posedge clk); #1;
      drainAll();

      // Simultaneous accept and pop at level 3
      applyStimulus(32'h5000, {32'h50000002, 32'h50000001}, 1'b0);
      applyStimulus(32'h5008, {32'h50000004, 32'h50000003}, 1'b0);
      popOne();
      bus.out_rdy = 1'b1;
      applyStimulus(32'h5010, {32'h50000006, 32'h50000005}, 1'b0);
      bus.out_rdy = 1'b0;
      @(negedge clk);
      checkOutput("simul_level", 64'(level), 64'(4));
      checkOutput("simul_head", 64'(bus.out_addr), 64'(32'h5008));
      @(posedge clk); #1;
      drainAll();

      // Error flag follows its beat only
      applyStimulus(32'h3000, {32'h30000002, 32'h30000001}, 1'b1);
      applyStimulus(32'h3008, {32'h30000004, 32'h30000003}, 1'b0);
      @(negedge clk);
      checkOutput("err_head", 64'(bus.out_err), 64'(1));
      @(posedge clk); #1;
      drainAll();

      // Flush at level 5 with a beat offered and consumer ready
      applyStimulus(32'h6000, {32'h60000002, 32'h60000001}, 1'b0);
      applyStimulus(32'h6008, {32'h60000004, 32'h60000003}, 1'b0);
      applyStimulus(32'h6014, {32'h60000006, 32'h60000005}, 1'b0);
      @(negedge clk);
      checkOutput("pre_flush_level", 64'(level), 64'(5));
      @(posedge clk); #1;
      flush = 1'b1;
      bus.in_vld  = 1'b1;
      bus.in_addr = 32'h7000;
      bus.in_data = {32'h70000002, 32'h70000001};
      bus.out_rdy = 1'b1;
      @(negedge clk);
      checkOutput("flush_out_vld", 64'(bus.out_vld), 64'(0));
      checkOutput("flush_in_rdy", 64'(bus.in_rdy), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_vld = 1'b0;
      @(negedge clk);
      checkOutput("post_flush_level", 64'(level), 64'(0));
      checkOutput("post_flush_in_rdy", 64'(bus.in_rdy), 64'(1));
      checkOutput("post_flush_out_vld", 64'(bus.out_vld), 64'(0));
      @(posedge clk); #1;
      bus.out_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Normal operation resumes from pointer 0
      applyStimulus(32'h8000, {32'h80000002, 32'h80000001}, 1'b0);
      @(negedge clk);
      checkOutput("resume_addr", 64'(bus.out_addr), 64'(32'h8000));
      checkOutput("resume_inst", 64'(bus.out_inst), 64'(32'h80000001));
      @(posedge clk); #1;
      drainAll();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/c7bifu_iq_mw.md
Name: c7bifu_iq_mw

Overview:
- Parametrised instruction queue between the BIU fetch return path and decode.
- Each fetch beat carries FETCH_WORDS 32-bit instructions. A non-zero word offset in the beat address drops the leading words, which handles branch targets mid-line.
- Entries leave one per cycle through a valid/ready handshake. Each entry carries its PC and a fetch-error flag.
- Supersedes the fixed 4-entry, 2-word, stall-driven queue.

Parameters:
- DEPTH, 8, queue capacity in instructions; power of 2, at least 2*FETCH_WORDS.
- FETCH_WORDS, 2, instructions per fetch beat; power of 2, 1..8.
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- flush  in  1  synchronous queue clear (redirect)
- in_vld  in  1  fetch beat valid
- in_rdy  out  1  queue can accept a full beat
- in_addr  in  ADDR_W  byte address of first valid instruction in beat
- in_data  in  32*FETCH_WORDS  beat data; word j at bits [32j+31:32j]
- in_err  in  1  fetch error for whole beat
- out_vld  out  1  head entry valid
- out_rdy  in  1  consumer accepts head
- out_addr  out  ADDR_W  head instruction PC
- out_inst  out  32  head instruction
- out_err  out  1  head error flag
- level  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk.
  - All pointers, the count and every storage entry go to 0.
  - Outputs after reset: out_vld=0, out_addr=0, out_inst=0, out_err=0, level=0, in_rdy=1.
- Derived quantities:
  - OFF_W = log2(FETCH_WORDS). Word offset k = in_addr[OFF_W+1:2]; k=0 when FETCH_WORDS=1.
  - Beat base = in_addr with bits [OFF_W+1:0] cleared. in_addr[1:0] is ignored.
  - Words written n = FETCH_WORDS - k, always in range 1..FETCH_WORDS.
- Write (accept = in_vld & in_rdy):
  - Word k+i goes to slot (wr_ptr+i) mod DEPTH, for i=0..n-1.
  - Its address is base + 4*(k+i), truncated to ADDR_W.
  - in_err is copied to every written entry.
  - wr_ptr advances by n.
- in_rdy = ~flush & (DEPTH - level >= FETCH_WORDS).
  - The check is conservative, independent of k.
  - It uses registered level only; a same-cycle pop does not enable a write.
- Read:
  - out_vld = ~flush & (level != 0).
  - out_addr, out_inst and out_err are driven combinationally from slot rd_ptr, so there is zero-latency presentation.
  - On pop = out_vld & out_rdy, rd_ptr advances by 1.
  - While out_vld=0 the data outputs hold the stale slot contents; consumers must ignore them.
- Level: next level = level + (accept ? n : 0) - (pop ? 1 : 0).
  - Simultaneous accept and pop are both applied.
  - level never exceeds DEPTH and never underflows.
- Pointers:
  - rd_ptr and wr_ptr are log2(DEPTH)+1 bits wide; wrap is modulo DEPTH on the index bits.
  - A single beat may straddle the array end, e.g. wr_ptr index DEPTH-1 with n=2 writes slots DEPTH-1 and 0.
- Flush:
  - Has priority over everything.
  - Same cycle: in_rdy=0 and out_vld=0, so no accept and no pop.
  - Next edge: pointers and level go to 0. Storage need not be cleared.
  - Next cycle: out_vld=0 and in_rdy=1.
- Backpressure: with out_rdy=0 the head and its outputs stay stable until popped.
- No combinational path from in_* to out_*. A beat written at edge t is visible at the earliest in the cycle after t.

Test Plan:
- Reset, then DEPTH=8, FETCH=2: beat in_addr=0x1000, data={0xBBBB0002,0xAAAA0001}, out_rdy=0 -> next cycle level=2, out_vld=1, out_addr=0x1000, out_inst=0xAAAA0001. After pop: out_addr=0x1004, out_inst=0xBBBB0002.
- Unaligned beat in_addr=0x2004, data={0x22,0x11} -> only 0x22 is written, at PC 0x2004; level=1.
- Fill with out_rdy=0: four aligned beats -> level=8, in_rdy=0. At level=7, in_rdy=0. A 5th beat held at in_vld=1 is accepted only after level drops to 6.
- Simultaneous accept (n=2) and pop at level=3 -> level=4 next cycle. Order is preserved across the wrap from slot 7 to slot 0 with correct PCs.
- in_err=1 on beat 0x3000 -> both entries pop with out_err=1. The following clean beat pops with out_err=0.
- flush asserted with level=5, in_vld=1, out_rdy=1 -> in the flush cycle out_vld=0 and in_rdy=0. Next cycle level=0 and in_rdy=1. Nothing from the flush-cycle beat ever appears at the output.
